rx_packet_deframer: RTL and testbench
=====================================

# rx_packet_deframer

Parametrised byte-stream packet deframer for the UART receive path. It hunts for a configurable sync word, then reads a little-endian length field of configurable width and a reserved zero byte, then forwards exactly that many payload bytes with a last-byte marker. Compared with the fixed-format parser, it adds overlapping-sync re-hunt, length bounds checking, an inter-byte idle timeout and error reporting. It sits between the UART RX byte source and the compressor input stream.

## Interface
- SYNC_LEN, 8, sync word length in bytes (1..8)
- SYNC_WORD, 64'h06B730981DFC9AEB, sync bytes; byte k = SYNC_WORD[8k+7:8k], byte 0 received first
- LEN_BYTES, 3, length field bytes (1..4); length width LW = 8*LEN_BYTES
- MAX_LEN, 2**24-1, largest accepted payload length
- TIMEOUT_CYCLES, 1000000, idle clk cycles between accepted bytes before abort; 0 disables timeout
- clk  input  1  clock
- rstn  input  1  asynchronous active-low reset
- i_en  input  1  input byte valid, single-cycle strobe
- i_data  input  8  input byte
- o_en  output  1  payload byte valid
- o_data  output  8  payload byte; 0 when o_en=0
- o_last  output  1  high with o_en on the final payload byte
- during_packet  output  1  combinational, high while state==DATA
- o_pkt_done  output  1  one-cycle pulse: packet accepted with no error
- o_err  output  1  one-cycle pulse: packet aborted
- o_err_code  output  2  valid with o_err: 1 timeout, 2 bad length, 3 checksum, 0 otherwise

## Operation
- States: SYNC, LEN, ZERO, DATA, CSUM (CSUM only with macro). Byte index counter idx is shared by SYNC and LEN.
- SYNC: on i_en, if i_data==sync byte idx, then idx++; after byte SYNC_LEN-1 → LEN, idx=0. On mismatch: if i_data==sync byte 0, then idx=1, else idx=0. No error is reported for sync mismatches.
- LEN: byte idx goes to len[8idx+7:8idx]; after LEN_BYTES bytes → ZERO.
- ZERO: i_data!=0 → SYNC silently. len==0 or len>MAX_LEN → o_err, code 2, → SYNC. Otherwise → DATA, with remaining count rem=len.
- DATA: each i_en gives o_en=1, o_data=i_data, rem--. At rem==1, o_last=1 and the FSM → SYNC (no macro) or → CSUM (macro).
- The remaining counter rem is LW bits wide. Length comparisons are unsigned at LW bits.
- Timeout: an idle counter clears on every i_en and on entry to SYNC with idx=0. It counts in every other state. When it reaches TIMEOUT_CYCLES: o_err, code 1, → SYNC with idx=0, no o_last. A truncated payload is possible; downstream relies on o_err to detect it.
- Simultaneous timeout expiry and i_en: the byte wins and the counter clears.
- Outputs default to 0 every cycle unless set as above.

## Timing
- All outputs except during_packet are registered, with 1-cycle latency from the i_en cycle.
- Without macro: o_pkt_done is asserted in the same cycle as o_last.
- Reset: every output is 0, state=SYNC, idx=0, rem=0, idle counter=0, checksum accumulator=0.
- rstn asserted mid-packet discards the packet with no o_last and no o_err.
- No backpressure. The block accepts back-to-back i_en on every cycle.

## Configuration
- RX_PKT_CHECKSUM_EN
  - Defined: an 8-bit mod-256 sum of the payload bytes is accumulated, and one trailer byte follows the payload (state CSUM, not forwarded on o_data). If trailer==sum, o_pkt_done is pulsed; otherwise o_err is pulsed with code 3. Either way → SYNC. The timeout applies in CSUM.
  - Undefined: there is no CSUM state and no accumulator, and o_err_code 3 never occurs.

## Structure
- Package rx_pkt_pkg holds:
  - the state encoding: SYNC=0, LEN=1, ZERO=2, DATA=3, CSUM=4 (3-bit);
  - the error codes: ERR_NONE=0, ERR_TIMEOUT=1, ERR_LEN=2, ERR_CSUM=3.
- Sub-module rx_idle_timer (parameter TIMEOUT_CYCLES; inputs clear and run; output expire pulse). Its counter width is $clog2(TIMEOUT_CYCLES+1). It is tied off when TIMEOUT_CYCLES==0.

## Test plan
- Default params: send EB 9A FC 1D 98 30 B7 06, 03 00 00, 00, 11 22 33 → o_en ×3 with data 11, 22, 33; o_last and o_pkt_done on 33; during_packet drops after 33.
- Stream EB EB 9A FC 1D 98 30 B7 06 01 00 00 00 5A → re-hunt succeeds; single o_en with 5A, o_last=1.
- Valid sync, length 00 00 00, zero byte → o_err=1, code 2, no o_en. The next valid packet is parsed normally.
- TIMEOUT_CYCLES=100, length 5, send 2 payload bytes then idle → o_err with code 1 exactly 100 cycles after the last byte, no o_last. A following packet is parsed normally.
- Macro defined, payload 01 02 03: trailer 06 → o_pkt_done; trailer 07 → o_err with code 3; o_data never shows the trailer.
- rstn pulsed low after 2 of 4 payload bytes → all outputs 0 during reset, no o_err. The next full packet is accepted.

Source files
------------

// File: rtl/rx_pkt_pkg.sv
// rx_pkt_pkg - shared definitions for the rx_packet_deframer slice.
//   rx_state_e : deframer FSM state encoding (3 bits)
//   rx_err_e   : error code reported on o_err_code
package rx_pkt_pkg;

    typedef enum logic [2:0] {
        SYNC = 3'd0,
        LEN  = 3'd1,
        ZERO = 3'd2,
        DATA = 3'd3,
        CSUM = 3'd4
    } rx_state_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_TIMEOUT = 2'd1,
        ERR_LEN     = 2'd2,
        ERR_CSUM    = 2'd3
    } rx_err_e;

    // Byte k of a packed 64-bit word, byte 0 in bits [7:0].
    function automatic logic [7:0] word_byte(input logic [63:0] w, input logic [2:0] k);
        return 8'(w >> {k, 3'b000});
    endfunction

endpackage

// File: rtl/rx_idle_timer.sv
// rx_idle_timer - inter-byte idle counter for the deframer.
//   clk, rstn  : clock, asynchronous active-low reset
//   clear_i    : restart the idle count (a byte was accepted)
//   run_i      : count while high; held at zero while low
//   expire_o   : one-cycle pulse when the idle count reaches TIMEOUT_CYCLES
// TIMEOUT_CYCLES == 0 removes the counter and expire_o stays low.
module rx_idle_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rstn,
    input  logic clear_i,
    input  logic run_i,
    output logic expire_o
);

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_off
            logic unused_in;
            assign unused_in = clear_i ^ run_i ^ clk ^ rstn;
            assign expire_o  = 1'b0;
        end else begin : g_on
            localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
            logic [CW-1:0] cnt_q;
            logic [CW-1:0] cnt_d;
            logic          hit;

            // Fires on the idle cycle whose increment would bring the count to
            // TIMEOUT_CYCLES; an accepted byte in the same cycle suppresses it.
            assign hit = run_i && !clear_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

            always_comb begin
                cnt_d = cnt_q;
                if (clear_i || !run_i || hit) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign expire_o = hit;
        end
    endgenerate

endmodule

// File: rtl/rx_packet_deframer.sv
// rx_packet_deframer - byte-stream packet deframer for the UART RX path.
// Frame: SYNC_LEN sync bytes, LEN_BYTES little-endian length, one zero byte,
// then `length` payload bytes (plus one checksum trailer when enabled).
//   clk, rstn       : clock, asynchronous active-low reset
//   i_en, i_data    : input byte strobe and byte
//   o_en, o_data    : forwarded payload byte (o_data is 0 when o_en is low)
//   o_last          : with o_en on the final payload byte
//   during_packet   : combinational, high while in DATA
//   o_pkt_done      : pulse, packet accepted
//   o_err           : pulse, packet aborted; o_err_code gives the reason
// Build option: define RX_PKT_CHECKSUM_EN to expect a mod-256 payload sum
// trailer byte after the payload (checked, never forwarded).
//
// state | meaning
// SYNC  | hunting for the sync word, idx = sync bytes matched so far
// LEN   | collecting length byte idx
// ZERO  | expecting the reserved zero byte, then length bounds check
// DATA  | forwarding payload, rem = bytes still to come
// CSUM  | expecting the checksum trailer (checksum build only)
module rx_packet_deframer
    import rx_pkt_pkg::*;
#(
    parameter int unsigned SYNC_LEN       = 8,
    parameter logic [63:0] SYNC_WORD      = 64'h06B730981DFC9AEB,
    parameter int unsigned LEN_BYTES      = 3,
    parameter int unsigned MAX_LEN        = 32'h00FF_FFFF,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       i_en,
    input  logic [7:0] i_data,
    output logic       o_en,
    output logic [7:0] o_data,
    output logic       o_last,
    output logic       during_packet,
    output logic       o_pkt_done,
    output logic       o_err,
    output logic [1:0] o_err_code
);

    localparam int LW = 8 * LEN_BYTES;

    rx_state_e   state_q;
    logic [2:0]  idx_q;
    logic [LW-1:0] len_q;
    logic [LW-1:0] rem_q;
    logic        o_en_q;
    logic [7:0]  o_data_q;
    logic        o_last_q;
    logic        o_pkt_done_q;
    logic        o_err_q;
    logic [1:0]  o_err_code_q;
`ifdef RX_PKT_CHECKSUM_EN
    logic [7:0]  csum_q;
`endif

    logic [7:0]  sync_b;
    logic        sync_idle;
    logic        tmo;

    assign sync_b    = word_byte(SYNC_WORD, idx_q);
    // Idle hunting is not "inside" a packet, so the timer is held there.
    assign sync_idle = (state_q == SYNC) && (idx_q == 3'd0);

    rx_idle_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_idle (
        .clk     (clk),
        .rstn    (rstn),
        .clear_i (i_en),
        .run_i   (!sync_idle),
        .expire_o(tmo)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= SYNC;
            idx_q        <= '0;
            len_q        <= '0;
            rem_q        <= '0;
            o_en_q       <= 1'b0;
            o_data_q     <= '0;
            o_last_q     <= 1'b0;
            o_pkt_done_q <= 1'b0;
            o_err_q      <= 1'b0;
            o_err_code_q <= ERR_NONE;
`ifdef RX_PKT_CHECKSUM_EN
            csum_q       <= '0;
`endif
        end else begin
            o_en_q       <= 1'b0;
            o_data_q     <= '0;
            o_last_q     <= 1'b0;
            o_pkt_done_q <= 1'b0;
            o_err_q      <= 1'b0;
            o_err_code_q <= ERR_NONE;

            if (i_en) begin
                case (state_q)
                    SYNC: begin
                        if (i_data == sync_b) begin
                            if (idx_q == 3'(SYNC_LEN - 1)) begin
                                state_q <= LEN;
                                idx_q   <= '0;
                            end else begin
                                idx_q <= idx_q + 3'd1;
                            end
                        end else if (i_data == SYNC_WORD[7:0]) begin
                            // The breaking byte may itself start a new sync word.
                            idx_q <= 3'd1;
                        end else begin
                            idx_q <= '0;
                        end
                    end
                    LEN: begin
                        for (int k = 0; k < int'(LEN_BYTES); k++) begin
                            if (idx_q == 3'(k)) begin
                                len_q[8*k +: 8] <= i_data;
                            end
                        end
                        if (idx_q == 3'(LEN_BYTES - 1)) begin
                            state_q <= ZERO;
                            idx_q   <= '0;
                        end else begin
                            idx_q <= idx_q + 3'd1;
                        end
                    end
                    ZERO: begin
                        state_q <= SYNC;
                        idx_q   <= '0;
                        if (i_data != 8'd0) begin
                            // Malformed header: drop silently and re-hunt.
                        end else if ((len_q == '0) || (32'(len_q) > MAX_LEN)) begin
                            o_err_q      <= 1'b1;
                            o_err_code_q <= ERR_LEN;
                        end else begin
                            state_q <= DATA;
                            rem_q   <= len_q;
`ifdef RX_PKT_CHECKSUM_EN
                            csum_q  <= '0;
`endif
                        end
                    end
                    DATA: begin
                        o_en_q   <= 1'b1;
                        o_data_q <= i_data;
                        rem_q    <= rem_q - 1'b1;
`ifdef RX_PKT_CHECKSUM_EN
                        csum_q   <= csum_q + i_data;
`endif
                        if (rem_q == LW'(1)) begin
                            o_last_q <= 1'b1;
                            idx_q    <= '0;
`ifdef RX_PKT_CHECKSUM_EN
                            state_q  <= CSUM;
`else
                            state_q      <= SYNC;
                            o_pkt_done_q <= 1'b1;
`endif
                        end
                    end
`ifdef RX_PKT_CHECKSUM_EN
                    CSUM: begin
                        state_q <= SYNC;
                        idx_q   <= '0;
                        if (i_data == csum_q) begin
                            o_pkt_done_q <= 1'b1;
                        end else begin
                            o_err_q      <= 1'b1;
                            o_err_code_q <= ERR_CSUM;
                        end
                    end
`endif
                    default: begin
                        state_q <= SYNC;
                        idx_q   <= '0;
                    end
                endcase
            end else if (tmo) begin
                state_q      <= SYNC;
                idx_q        <= '0;
                o_err_q      <= 1'b1;
                o_err_code_q <= ERR_TIMEOUT;
            end
        end
    end

    assign o_en          = o_en_q;
    assign o_data        = o_data_q;
    assign o_last        = o_last_q;
    assign o_pkt_done    = o_pkt_done_q;
    assign o_err         = o_err_q;
    assign o_err_code    = o_err_code_q;
    assign during_packet = (state_q == DATA);

endmodule

// File: tb/tb_rx_packet_deframer.sv
// Directed bench for rx_packet_deframer (MAX_LEN=16, TIMEOUT_CYCLES=100).
// Also builds with RX_PKT_CHECKSUM_EN defined; packets then carry a trailer.
module tb_rx_packet_deframer;

    typedef logic [7:0] bq_t[$];

    localparam logic [63:0] SYNC = 64'h06B730981DFC9AEB;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       i_en = 1'b0;
    logic [7:0] i_data = 8'h00;
    logic       o_en;
    logic [7:0] o_data;
    logic       o_last;
    logic       during_packet;
    logic       o_pkt_done;
    logic       o_err;
    logic [1:0] o_err_code;

    always #5 clk = ~clk;

    rx_packet_deframer #(
        .SYNC_LEN      (8),
        .SYNC_WORD     (SYNC),
        .LEN_BYTES     (3),
        .MAX_LEN       (16),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .i_en         (i_en),
        .i_data       (i_data),
        .o_en         (o_en),
        .o_data       (o_data),
        .o_last       (o_last),
        .during_packet(during_packet),
        .o_pkt_done   (o_pkt_done),
        .o_err        (o_err),
        .o_err_code   (o_err_code)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Output monitor, sampled on the falling edge.
    bq_t        rx_q;
    int         n_en, n_last, n_done, n_done_last, n_err, n_viol;
    logic [1:0] err_code;
    logic [7:0] last_data;
    int         cyc = 0;
    int         en_cyc, err_cyc;

    task automatic clear_stats();
        rx_q = {};
        n_en = 0; n_last = 0; n_done = 0; n_done_last = 0; n_err = 0;
        err_code = 2'd0; last_data = 8'h00; en_cyc = 0; err_cyc = 0;
    endtask

    initial begin
        n_viol = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (o_en) begin
                rx_q.push_back(o_data);
                n_en++;
                en_cyc = cyc;
            end else if (o_data != 8'h00) begin
                n_viol++;
            end
            if (o_last) begin
                n_last++;
                last_data = o_data;
                if (!o_en) n_viol++;
            end
            if (o_pkt_done) begin
                n_done++;
                if (o_last) n_done_last++;
            end
            if (o_err) begin
                n_err++;
                err_code = o_err_code;
                err_cyc = cyc;
            end else if (o_err_code != 2'd0) begin
                n_viol++;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        i_en = 1'b1;
        i_data = b;
        @(posedge clk);
        #1;
        i_en = 1'b0;
        i_data = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_hdr(input logic [23:0] len, input logic [7:0] zb);
        logic [63:0] w;
        w = SYNC;
        for (int k = 0; k < 8; k++) send_byte(w[8*k +: 8]);
        send_byte(len[7:0]);
        send_byte(len[15:8]);
        send_byte(len[23:16]);
        send_byte(zb);
    endtask

    task automatic send_body(input bq_t p, input bit bad_csum);
        logic [7:0] s;
        s = 8'h00;
        foreach (p[i]) begin
            send_byte(p[i]);
            s = s + p[i];
        end
`ifdef RX_PKT_CHECKSUM_EN
        send_byte(bad_csum ? s + 8'h01 : s);
`else
        if (bad_csum) s = 8'h00;
`endif
    endtask

    task automatic check_pkt(input string tag, input bq_t exp);
        idle(3);
        chk_eq({tag, "_n_en"}, n_en, exp.size());
        foreach (exp[i]) begin
            if (i < rx_q.size()) chk_eq($sformatf("%s_byte%0d", tag, i), rx_q[i], exp[i]);
        end
        chk_eq({tag, "_n_last"}, n_last, 1);
        chk_eq({tag, "_last_data"}, last_data, exp[exp.size()-1]);
        chk_eq({tag, "_n_done"}, n_done, 1);
        chk_eq({tag, "_n_err"}, n_err, 0);
`ifdef RX_PKT_CHECKSUM_EN
        chk_eq({tag, "_done_with_last"}, n_done_last, 0);
`else
        chk_eq({tag, "_done_with_last"}, n_done_last, 1);
`endif
    endtask

    function automatic logic [31:0] outs_vec();
        return {19'd0, o_en, o_data, o_last, o_pkt_done, o_err, o_err_code, during_packet};
    endfunction

    initial begin
        bq_t p;
        clear_stats();

        // Reset state
        idle(3);
        chk_eq("reset_outs", outs_vec(), 32'd0);
        rstn = 1'b1;
        idle(2);
        chk_eq("after_reset_outs", outs_vec(), 32'd0);

        // Basic packet
        clear_stats();
        send_hdr(24'd3, 8'h00);
        chk_eq("dp_in_data", during_packet, 1);
        p = '{8'h11, 8'h22, 8'h33};
        foreach (p[i]) send_byte(p[i]);
        chk_eq("dp_after_last", during_packet, 0);
`ifdef RX_PKT_CHECKSUM_EN
        send_byte(8'h66);
`endif
        check_pkt("basic", p);

        // Overlapping sync re-hunt
        clear_stats();
        send_byte(8'hEB);
        send_hdr(24'd1, 8'h00);
        p = '{8'h5A};
        send_body(p, 1'b0);
        check_pkt("rehunt", p);

        // Zero length
        clear_stats();
        send_hdr(24'd0, 8'h00);
        idle(3);
        chk_eq("len0_err", n_err, 1);
        chk_eq("len0_code", err_code, 2);
        chk_eq("len0_n_en", n_en, 0);
        clear_stats();
        send_hdr(24'd1, 8'h00);
        p = '{8'h77};
        send_body(p, 1'b0);
        check_pkt("after_len0", p);

        // Length above MAX_LEN, and a high length byte
        clear_stats();
        send_hdr(24'd17, 8'h00);
        idle(3);
        chk_eq("len17_err", n_err, 1);
        chk_eq("len17_code", err_code, 2);
        clear_stats();
        send_hdr(24'h010000, 8'h00);
        idle(3);
        chk_eq("len64k_err", n_err, 1);
        chk_eq("len64k_code", err_code, 2);
        chk_eq("len64k_n_en", n_en, 0);
        clear_stats();
        send_hdr(24'd16, 8'h00);
        p = {};
        for (int i = 0; i < 16; i++) p.push_back(8'(3*i + 1));
        send_body(p, 1'b0);
        check_pkt("len_max", p);

        // Nonzero reserved byte drops silently
        clear_stats();
        send_hdr(24'd2, 8'h01);
        send_byte(8'hAA);
        send_byte(8'hAA);
        idle(3);
        chk_eq("zb_n_err", n_err, 0);
        chk_eq("zb_n_en", n_en, 0);
        clear_stats();
        send_hdr(24'd2, 8'h00);
        p = '{8'hC3, 8'h3C};
        send_body(p, 1'b0);
        check_pkt("after_zb", p);

        // Timeout mid-payload
        clear_stats();
        send_hdr(24'd5, 8'h00);
        send_byte(8'hA1);
        send_byte(8'hA2);
        idle(110);
        chk_eq("tmo_n_en", n_en, 2);
        chk_eq("tmo_n_last", n_last, 0);
        chk_eq("tmo_n_err", n_err, 1);
        chk_eq("tmo_code", err_code, 1);
        chk_eq("tmo_delay", err_cyc - en_cyc, 100);
        chk_eq("tmo_n_done", n_done, 0);
        clear_stats();
        send_hdr(24'd1, 8'h00);
        p = '{8'hD4};
        send_body(p, 1'b0);
        check_pkt("after_tmo", p);

`ifdef RX_PKT_CHECKSUM_EN
        // Checksum trailer good / bad
        clear_stats();
        send_hdr(24'd3, 8'h00);
        p = '{8'h01, 8'h02, 8'h03};
        send_body(p, 1'b0);
        check_pkt("csum_ok", p);
        clear_stats();
        send_hdr(24'd3, 8'h00);
        send_body(p, 1'b1);
        idle(3);
        chk_eq("csum_bad_n_en", n_en, 3);
        chk_eq("csum_bad_n_done", n_done, 0);
        chk_eq("csum_bad_n_err", n_err, 1);
        chk_eq("csum_bad_code", err_code, 3);
`endif

        // Reset mid-packet
        clear_stats();
        send_hdr(24'd4, 8'h00);
        send_byte(8'hB1);
        send_byte(8'hB2);
        idle(1);
        rstn = 1'b0;
        #2;
        chk_eq("midrst_outs", outs_vec(), 32'd0);
        idle(2);
        chk_eq("midrst_outs_held", outs_vec(), 32'd0);
        rstn = 1'b1;
        idle(3);
        chk_eq("midrst_n_en", n_en, 2);
        chk_eq("midrst_n_last", n_last, 0);
        chk_eq("midrst_n_err", n_err, 0);
        clear_stats();
        send_hdr(24'd4, 8'h00);
        p = '{8'hE1, 8'hE2, 8'hE3, 8'hE4};
        send_body(p, 1'b0);
        check_pkt("after_midrst", p);

        chk_eq("idle_output_rules", n_viol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
